// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet accelerator load/control path.
// Holds parameter defaults, write-target encoding, register map and FSM states.
package lenet_pkg;

    localparam int unsigned N_WEIGHT_DEF = 3220;
    localparam int unsigned N_BIAS_DEF   = 10;
    localparam int unsigned N_FMAP_DEF   = 784;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_WGT  = 2'b01;
    localparam logic [1:0] SEL_BIAS = 2'b10;
    localparam logic [1:0] SEL_FMAP = 2'b11;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_WGT      = 8'h04;
    localparam logic [7:0] REG_BIAS     = 8'h08;
    localparam logic [7:0] REG_FMAP     = 8'h0C;
    localparam logic [7:0] REG_DONE     = 8'h14;
    localparam logic [7:0] REG_RESULT   = 8'h18;
    localparam logic [7:0] REG_SOFT_CLR = 8'h1C;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StDone
    } ctrl_state_e;

    // Address width for an n-entry memory, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lenet_load_cnt.sv
// Saturating per-target write counter: counts 0..MAX, refuses increments once
// full and flags the refused increment as an overflow.
module lenet_load_cnt #(
    parameter int unsigned MAX = 10,
    parameter int unsigned AW  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          full_o,
    output logic          last_o,
    output logic          ovf_o
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (inc_i && !full_o) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign full_o = (count_q == CW'(MAX));
    assign last_o = (count_q == CW'(MAX - 1));
    assign ovf_o  = inc_i && full_o;
    // Only meaningful while not full, where the count always fits in AW bits.
    assign addr_o = count_q[AW-1:0];

endmodule

// File: rtl/lenet_load_ctrl.sv
// Load/run controller: streams weight, bias and pixel register writes into the
// local memories, kicks the conv/FC core once all three are full, captures the class.
module lenet_load_ctrl
    import lenet_pkg::*;
#(
    parameter int unsigned N_WEIGHT = N_WEIGHT_DEF,
    parameter int unsigned N_BIAS   = N_BIAS_DEF,
    parameter int unsigned N_FMAP   = N_FMAP_DEF,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        cfg_run_i,
    input  logic                        soft_clr_i,
    input  logic                        wr_valid_i,
    input  logic [1:0]                  wr_sel_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    output logic                        wgt_we_o,
    output logic [addr_w(N_WEIGHT)-1:0] wgt_addr_o,
    output logic                        bias_we_o,
    output logic [addr_w(N_BIAS)-1:0]   bias_addr_o,
    output logic                        fmap_we_o,
    output logic [addr_w(N_FMAP)-1:0]   fmap_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic                        core_start_o,
    input  logic                        core_done_i,
    input  logic [3:0]                  core_class_i,
    output logic                        done_o,
    output logic [3:0]                  result_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int unsigned WGT_AW  = addr_w(N_WEIGHT);
    localparam int unsigned BIAS_AW = addr_w(N_BIAS);
    localparam int unsigned FMAP_AW = addr_w(N_FMAP);

    ctrl_state_e state_q, state_d;

    logic rst;
    logic run_abort, cnt_clr, load_wr, wr_err, all_full;
    logic wgt_inc, wgt_fire, wgt_full, wgt_last, wgt_ovf;
    logic bias_inc, bias_fire, bias_full, bias_last, bias_ovf;
    logic fmap_inc, fmap_fire, fmap_full, fmap_last, fmap_ovf;
    logic [WGT_AW-1:0]  wgt_cnt, wgt_addr_q;
    logic [BIAS_AW-1:0] bias_cnt, bias_addr_q;
    logic [FMAP_AW-1:0] fmap_cnt, fmap_addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               wgt_we_q, bias_we_q, fmap_we_q;
    logic               core_start_q, core_start_d;
    logic               done_q, done_d;
    logic [3:0]         result_q, result_d;
    logic               err_q;

    // Soft clear is indistinguishable from a hardware reset.
    assign rst       = ARESET || soft_clr_i;
    assign run_abort = !cfg_run_i && (state_q inside {StLoad, StStart, StRun});
    assign cnt_clr   = (state_q == StIdle) || run_abort;
    assign load_wr   = (state_q == StLoad) && cfg_run_i && wr_valid_i;

    assign wgt_inc  = load_wr && (wr_sel_i == SEL_WGT);
    assign bias_inc = load_wr && (wr_sel_i == SEL_BIAS);
    assign fmap_inc = load_wr && (wr_sel_i == SEL_FMAP);

    assign wgt_fire  = wgt_inc && !wgt_full;
    assign bias_fire = bias_inc && !bias_full;
    assign fmap_fire = fmap_inc && !fmap_full;

    lenet_load_cnt #(.MAX(N_WEIGHT), .AW(WGT_AW)) u_wgt_cnt (
        .clk_i  (ACLK),
        .rst_i  (rst),
        .clr_i  (cnt_clr),
        .inc_i  (wgt_inc),
        .addr_o (wgt_cnt),
        .full_o (wgt_full),
        .last_o (wgt_last),
        .ovf_o  (wgt_ovf)
    );

    lenet_load_cnt #(.MAX(N_BIAS), .AW(BIAS_AW)) u_bias_cnt (
        .clk_i  (ACLK),
        .rst_i  (rst),
        .clr_i  (cnt_clr),
        .inc_i  (bias_inc),
        .addr_o (bias_cnt),
        .full_o (bias_full),
        .last_o (bias_last),
        .ovf_o  (bias_ovf)
    );

    lenet_load_cnt #(.MAX(N_FMAP), .AW(FMAP_AW)) u_fmap_cnt (
        .clk_i  (ACLK),
        .rst_i  (rst),
        .clr_i  (cnt_clr),
        .inc_i  (fmap_inc),
        .addr_o (fmap_cnt),
        .full_o (fmap_full),
        .last_o (fmap_last),
        .ovf_o  (fmap_ovf)
    );

    // True when every counter is full once this cycle's write lands.
    assign all_full = (wgt_full || (wgt_fire && wgt_last)) &&
                      (bias_full || (bias_fire && bias_last)) &&
                      (fmap_full || (fmap_fire && fmap_last));

    // An aborting cycle swallows any concurrent write without flagging it.
    assign wr_err = wr_valid_i && !run_abort &&
                    ((state_q != StLoad) || (wr_sel_i == SEL_NONE) ||
                     wgt_ovf || bias_ovf || fmap_ovf);

    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        done_d       = done_q;
        result_d     = result_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_run_i) state_d = StLoad;
            end
            StLoad: begin
                if (!cfg_run_i)    state_d = StIdle;
                else if (all_full) state_d = StStart;
            end
            StStart: begin
                // Two cycles here: request the pulse, then leave as it is driven.
                if (!cfg_run_i) begin
                    state_d = StIdle;
                end else if (core_start_q) begin
                    state_d = StRun;
                end else begin
                    core_start_d = 1'b1;
                end
            end
            StRun: begin
                if (!cfg_run_i) begin
                    state_d = StIdle;
                end else if (core_done_i) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    result_d = core_class_i;
                end
            end
            StDone: begin
                if (!cfg_run_i) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (rst) begin
            state_q      <= StIdle;
            wgt_we_q     <= 1'b0;
            bias_we_q    <= 1'b0;
            fmap_we_q    <= 1'b0;
            wgt_addr_q   <= '0;
            bias_addr_q  <= '0;
            fmap_addr_q  <= '0;
            wdata_q      <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wgt_we_q     <= wgt_fire;
            bias_we_q    <= bias_fire;
            fmap_we_q    <= fmap_fire;
            if (wgt_fire)  wgt_addr_q  <= wgt_cnt;
            if (bias_fire) bias_addr_q <= bias_cnt;
            if (fmap_fire) fmap_addr_q <= fmap_cnt;
            if (wgt_fire || bias_fire || fmap_fire) wdata_q <= wr_data_i;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            result_q     <= result_d;
            err_q        <= err_q || wr_err;
        end
    end

    assign wgt_we_o     = wgt_we_q;
    assign bias_we_o    = bias_we_q;
    assign fmap_we_o    = fmap_we_q;
    assign wgt_addr_o   = wgt_addr_q;
    assign bias_addr_o  = bias_addr_q;
    assign fmap_addr_o  = fmap_addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_start_o = core_start_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign busy_o       = state_q inside {StLoad, StStart, StRun};
    assign err_o        = err_q;

endmodule

// File: tb/tb_lenet_load_ctrl.sv
// Directed bench for lenet_load_ctrl: vector table for protocol corners plus
// full-load, completion, overflow, abort, interleave and reset sequences.
module tb_lenet_load_ctrl;
    import lenet_pkg::*;

    localparam int NW = 3220;
    localparam int NB = 10;
    localparam int NF = 784;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_run_i = 1'b0;
    logic        soft_clr_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [1:0]  wr_sel_i = 2'b00;
    logic [31:0] wr_data_i = 32'd0;
    logic        wgt_we_o, bias_we_o, fmap_we_o;
    logic [11:0] wgt_addr_o;
    logic [3:0]  bias_addr_o;
    logic [9:0]  fmap_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_start_o;
    logic        core_done_i = 1'b0;
    logic [3:0]  core_class_i = 4'd0;
    logic        done_o;
    logic [3:0]  result_o;
    logic        busy_o, err_o;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    always #5 ACLK = ~ACLK;

    lenet_load_ctrl dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .cfg_run_i    (cfg_run_i),
        .soft_clr_i   (soft_clr_i),
        .wr_valid_i   (wr_valid_i),
        .wr_sel_i     (wr_sel_i),
        .wr_data_i    (wr_data_i),
        .wgt_we_o     (wgt_we_o),
        .wgt_addr_o   (wgt_addr_o),
        .bias_we_o    (bias_we_o),
        .bias_addr_o  (bias_addr_o),
        .fmap_we_o    (fmap_we_o),
        .fmap_addr_o  (fmap_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_start_o (core_start_o),
        .core_done_i  (core_done_i),
        .core_class_i (core_class_i),
        .done_o       (done_o),
        .result_o     (result_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always @(negedge ACLK) if (core_start_o) start_cnt++;

    typedef struct packed {
        logic        run;
        logic        valid;
        logic [1:0]  sel;
        logic [31:0] data;
        logic        clr;
        logic        cdone;
        logic [3:0]  cclass;
        logic [2:0]  exp_we;
        logic [11:0] exp_addr;
        logic        exp_err;
        logic        exp_busy;
        logic        exp_done;
        logic [3:0]  exp_result;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkdata(input logic [1:0] sel, input int idx);
        return {sel, 14'h2A5, idx[15:0]};
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, 32'({wgt_we_o, bias_we_o, fmap_we_o}), 32'd0);
        chk({tag, "_addr"}, 32'({wgt_addr_o, bias_addr_o, fmap_addr_o}), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_start"}, 32'(core_start_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_result"}, 32'(result_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    task automatic wr_raw(input logic [1:0] sel, input logic [31:0] data);
        wr_sel_i   = sel;
        wr_data_i  = data;
        wr_valid_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input int idx);
        logic [2:0] exp_we;
        logic [31:0] act_addr;
        exp_we = {sel == SEL_WGT, sel == SEL_BIAS, sel == SEL_FMAP};
        wr_raw(sel, mkdata(sel, idx));
        chk("we_vec", 32'({wgt_we_o, bias_we_o, fmap_we_o}), 32'(exp_we));
        act_addr = (sel == SEL_WGT)  ? 32'(wgt_addr_o) :
                   (sel == SEL_BIAS) ? 32'(bias_addr_o) : 32'(fmap_addr_o);
        chk("wr_addr", act_addr, 32'(idx));
        chk("wr_data", mem_wdata_o, mkdata(sel, idx));
    endtask

    // Called in the cycle after the final write's edge.
    task automatic expect_start();
        chk("start_n1", 32'(core_start_o), 32'd0);
        step();
        chk("start_n2", 32'(core_start_o), 32'd1);
        step();
        chk("start_n3", 32'(core_start_o), 32'd0);
        chk("busy_run", 32'(busy_o), 32'd1);
    endtask

    task automatic load_seq(input bit fmap_first);
        if (!fmap_first) begin
            for (int i = 0; i < NW; i++) wr(SEL_WGT, i);
            for (int i = 0; i < NB; i++) wr(SEL_BIAS, i);
            for (int i = 0; i < NF; i++) wr(SEL_FMAP, i);
        end else begin
            for (int i = 0; i < NF; i++) wr(SEL_FMAP, i);
            for (int i = 0; i < NB; i++) wr(SEL_BIAS, i);
            for (int i = 0; i < NW; i++) wr(SEL_WGT, i);
        end
        expect_start();
    endtask

    task automatic finish_image(input logic [3:0] cls, input string tag);
        core_done_i  = 1'b1;
        core_class_i = cls;
        step();
        core_done_i  = 1'b0;
        core_class_i = 4'd0;
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_result"}, 32'(result_o), 32'(cls));
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        step();
        chk({tag, "_done_hold"}, 32'(done_o), 32'd1);
        cfg_run_i = 1'b0;
        step();
        chk({tag, "_done_clr"}, 32'(done_o), 32'd0);
        chk({tag, "_result_keep"}, 32'(result_o), 32'(cls));
    endtask

    initial begin
        int s;
        logic [31:0] act_addr;

        //         run  vld  sel    data          clr  cdn  cls   we      addr   err  busy done res
        vecs[0] = '{1'b0, 1'b1, 2'b01, 32'h0000_1111, 1'b0, 1'b0, 4'd0, 3'b000, 12'd0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 4'd0, 3'b000, 12'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2] = '{1'b1, 1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b0, 4'd0, 3'b000, 12'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 1'b1, 2'b00, 32'h0000_2222, 1'b0, 1'b0, 4'd0, 3'b000, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[4] = '{1'b1, 1'b1, 2'b10, 32'h0000_BEEF, 1'b0, 1'b0, 4'd0, 3'b010, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 32'h0000_CAFE, 1'b0, 1'b0, 4'd0, 3'b001, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[6] = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b0, 4'd0, 3'b000, 12'd0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[7] = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1, 4'd9, 3'b000, 12'd0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[8] = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 4'd0, 3'b000, 12'd0, 1'b0, 1'b0, 1'b0, 4'd0};

        step();
        step();
        chk_reset("por");
        ARESET = 1'b0;

        // First image, sequential order, class 7.
        cfg_run_i = 1'b1;
        step();
        chk("busy_load", 32'(busy_o), 32'd1);
        s = start_cnt;
        load_seq(1'b0);
        chk("start_cnt_img1", 32'(start_cnt - s), 32'd1);
        chk("err_img1", 32'(err_o), 32'd0);
        finish_image(4'd7, "img1");

        // Second image, fmap first, class 3.
        cfg_run_i = 1'b1;
        step();
        load_seq(1'b1);
        chk("err_img2", 32'(err_o), 32'd0);
        finish_image(4'd3, "img2");

        // Weight overflow: dropped, sticky error, counter stays saturated.
        cfg_run_i = 1'b1;
        step();
        for (int i = 0; i < NW; i++) wr(SEL_WGT, i);
        chk("err_pre_ovf", 32'(err_o), 32'd0);
        wr_raw(SEL_WGT, mkdata(SEL_WGT, NW));
        chk("ovf_we", 32'({wgt_we_o, bias_we_o, fmap_we_o}), 32'd0);
        chk("ovf_err", 32'(err_o), 32'd1);
        chk("ovf_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < NB; i++) wr(SEL_BIAS, i);
        s = start_cnt;
        for (int i = 0; i < NF; i++) wr(SEL_FMAP, i);
        expect_start();
        chk("start_cnt_ovf", 32'(start_cnt - s), 32'd1);

        // Soft clear in RUN beats a simultaneous core_done.
        cfg_run_i    = 1'b0;
        soft_clr_i   = 1'b1;
        core_done_i  = 1'b1;
        core_class_i = 4'd5;
        step();
        soft_clr_i   = 1'b0;
        core_done_i  = 1'b0;
        core_class_i = 4'd0;
        chk_reset("soft_clr_run");
        step();
        chk("done_after_clr", 32'(done_o), 32'd0);

        // Protocol-corner vector table.
        for (int v = 0; v < 9; v++) begin
            cfg_run_i    = vecs[v].run;
            wr_valid_i   = vecs[v].valid;
            wr_sel_i     = vecs[v].sel;
            wr_data_i    = vecs[v].data;
            soft_clr_i   = vecs[v].clr;
            core_done_i  = vecs[v].cdone;
            core_class_i = vecs[v].cclass;
            step();
            wr_valid_i  = 1'b0;
            soft_clr_i  = 1'b0;
            core_done_i = 1'b0;
            chk($sformatf("vec%0d_we", v), 32'({wgt_we_o, bias_we_o, fmap_we_o}),
                32'(vecs[v].exp_we));
            chk($sformatf("vec%0d_err", v), 32'(err_o), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_busy", v), 32'(busy_o), 32'(vecs[v].exp_busy));
            chk($sformatf("vec%0d_done", v), 32'(done_o), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_result", v), 32'(result_o), 32'(vecs[v].exp_result));
            if (vecs[v].exp_we != 3'b000) begin
                act_addr = vecs[v].exp_we[2] ? 32'(wgt_addr_o) :
                           vecs[v].exp_we[1] ? 32'(bias_addr_o) : 32'(fmap_addr_o);
                chk($sformatf("vec%0d_addr", v), act_addr, 32'(vecs[v].exp_addr));
                chk($sformatf("vec%0d_wdata", v), mem_wdata_o, vecs[v].data);
            end
        end
        core_class_i = 4'd0;

        // Abort after 500 pixels, stray core_done ignored.
        cfg_run_i = 1'b1;
        step();
        s = start_cnt;
        for (int i = 0; i < 500; i++) wr(SEL_FMAP, i);
        cfg_run_i = 1'b0;
        step();
        chk("abort_busy", 32'(busy_o), 32'd0);
        core_done_i  = 1'b1;
        core_class_i = 4'd9;
        step();
        core_done_i  = 1'b0;
        core_class_i = 4'd0;
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_result", 32'(result_o), 32'd0);
        step();
        step();
        chk("abort_no_start", 32'(start_cnt - s), 32'd0);
        chk("abort_err", 32'(err_o), 32'd0);

        // Interleaved reload from address 0.
        cfg_run_i = 1'b1;
        step();
        s = start_cnt;
        for (int i = 0; i < NW; i++) begin
            if (i < NB) wr(SEL_BIAS, i);
            if (i < NF) wr(SEL_FMAP, i);
            wr(SEL_WGT, i);
        end
        expect_start();
        chk("start_cnt_ilv", 32'(start_cnt - s), 32'd1);
        chk("err_ilv", 32'(err_o), 32'd0);

        // Hardware reset mid-LOAD with a concurrent write.
        cfg_run_i = 1'b0;
        step();
        cfg_run_i = 1'b1;
        step();
        for (int i = 0; i < 20; i++) wr(SEL_WGT, i);
        ARESET     = 1'b1;
        wr_sel_i   = SEL_WGT;
        wr_data_i  = 32'hDEAD_BEEF;
        wr_valid_i = 1'b1;
        step();
        ARESET     = 1'b0;
        wr_valid_i = 1'b0;
        chk_reset("areset_load");
        step();
        wr(SEL_WGT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lenet_load_ctrl.md
LENET_LOAD_CTRL -- requirements
Module: lenet_load_ctrl

Interface
REQ-001 SHALL have parameter N_WEIGHT, default 3220, number of weight words per load.
REQ-002 SHALL have parameter N_BIAS, default 10, number of bias words per load.
REQ-003 SHALL have parameter N_FMAP, default 784, number of input-pixel words per image.
REQ-004 SHALL have parameter DATA_W, default 32, width of the register write data.
REQ-005 SHALL have ports: ACLK in 1, the single clock; ARESET in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: cfg_run_i in 1, level of control register 0x0 bit0; soft_clr_i in 1, one-cycle pulse from a write to register 0x1C.
REQ-007 SHALL have ports: wr_valid_i in 1, one-cycle pulse per register write; wr_sel_i in 2, target (01 weight/0x4, 10 bias/0x8, 11 fmap/0xC); wr_data_i in DATA_W, write data.
REQ-008 SHALL have ports: wgt_we_o out 1, wgt_addr_o out clog2(N_WEIGHT), bias_we_o out 1, bias_addr_o out clog2(N_BIAS), fmap_we_o out 1, fmap_addr_o out clog2(N_FMAP), mem_wdata_o out DATA_W.
REQ-009 SHALL have ports: core_start_o out 1, one-cycle start pulse to the conv/FC datapath; core_done_i in 1, completion pulse; core_class_i in 4, argmax class.
REQ-010 SHALL have ports: done_o out 1, drives status register 0x14; result_o out 4, drives register 0x18; busy_o out 1; err_o out 1, sticky protocol error.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, START, RUN, DONE.
REQ-012 IDLE: counters held at 0; cfg_run_i==1 -> LOAD next cycle.
REQ-013 LOAD: each wr_valid_i with a valid wr_sel_i SHALL write one word at the current per-target counter and then increment that counter.
REQ-014 Memory write timing: wr_valid_i in cycle n -> matching *_we_o=1 in cycle n+1, with addr = counter value and mem_wdata_o = wr_data_i, all registered; at most one we_o high per cycle.
REQ-015 Completion: when all three counters reach N_* (the final write is in cycle n, its we_o in n+1), the FSM SHALL go to START in n+1; core_start_o=1 for exactly cycle n+2; RUN in n+3.
REQ-016 Load order is free: targets may be interleaved; completion requires all three counts to be full.
REQ-017 Overflow: a write to a target whose counter == N_* SHALL be dropped (no we_o) and SHALL set err_o; the counter stays saturated.
REQ-018 Write errors: wr_sel_i==00, or any wr_valid_i outside LOAD, SHALL be dropped and SHALL set err_o.
REQ-019 RUN: core_done_i in cycle m -> result_o=core_class_i and done_o=1 from cycle m+1; state DONE.
REQ-020 DONE: done_o and result_o held; cfg_run_i==0 -> IDLE, done_o=0 next cycle; result_o keeps its last value.
REQ-021 Abort: cfg_run_i==0 in LOAD, START or RUN -> IDLE next cycle, counters cleared, no core_start_o; a core_done_i outside RUN SHALL be ignored.
REQ-022 busy_o SHALL be 1 exactly in LOAD, START and RUN.
REQ-023 soft_clr_i SHALL have the same effect as ARESET (all state, outputs, err_o) and takes priority over every other event in the same cycle.
REQ-024 Same-cycle events: soft_clr_i > abort > core_done_i > write.

Reset
REQ-025 On ARESET: state IDLE, all counters 0, all *_we_o 0, core_start_o 0, done_o 0, result_o 0, busy_o 0, err_o 0, addresses 0, mem_wdata_o 0.
REQ-026 Reset mid-LOAD or mid-RUN SHALL discard progress; no pulse SHALL be emitted in the cycle after reset.

Structure
REQ-027 The shared package lenet_pkg SHALL hold the N_WEIGHT/N_BIAS/N_FMAP defaults, the wr_sel encoding constants, the register offsets 0x0/0x4/0x8/0xC/0x14/0x18/0x1C, and the FSM state typedef.
REQ-028 Per-target counting SHALL use one sub-module, lenet_load_cnt, instantiated three times: saturating counter with clear, inc, full and overflow flag.

Verification
REQ-029 Full load: run=1; 3220 weight, 10 bias and 784 fmap writes -> wgt_addr 0..3219, bias_addr 0..9, fmap_addr 0..783 with data echoed; single core_start_o 2 cycles after the last write; err_o=0.
REQ-030 Completion: in RUN, core_done_i with class 7 -> done_o=1 and result_o=7 next cycle; run=0 -> done_o=0, result_o stays 7; a second image with class 3 -> result_o=3.
REQ-031 Overflow: a 3221st weight write -> no wgt_we_o, err_o=1; sel=00 write in LOAD -> dropped, err_o=1; write in IDLE -> dropped, err_o=1.
REQ-032 Abort: run=0 after 500 fmap writes -> IDLE, no core_start_o; a following core_done_i -> done_o stays 0; reload from addr 0 succeeds.
REQ-033 Interleaved order (bias, fmap, weights alternating) -> correct addresses, exactly one core_start_o.
REQ-034 soft_clr_i in RUN, and ARESET mid-LOAD -> all outputs at reset values next cycle; a simultaneous core_done_i is ignored.
